// File: rtl/joy_analog_cond.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : joy_analog_cond                                               |
// | Desc     : Analog-stick to 4-way direction conditioner with hysteresis,  |
// |            last-active player tracking and coin pulse stretching.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module joy_analog_cond #(
    parameter int NPLAYERS     = 2,
    parameter int DEADZONE     = 32,
    parameter int HYST         = 8,
    parameter int COIN_STRETCH = 16,
    parameter int PW           = (NPLAYERS > 1) ? $clog2(NPLAYERS) : 1
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [NPLAYERS*32-1:0] joy_dig,
    input  logic [NPLAYERS*16-1:0] joy_ana,
    output logic [NPLAYERS*4-1:0]  dir_out,
    output logic                  coin_out,
    output logic [PW-1:0]         active_player,
    output logic                  any_active
);

    localparam logic [1:0] c_CENTER = 2'd0;
    localparam logic [1:0] c_POS    = 2'd1;
    localparam logic [1:0] c_NEG    = 2'd2;

    localparam logic signed [8:0] c_ENGAGE  = 9'(DEADZONE);
    localparam logic signed [8:0] c_RELEASE = 9'(DEADZONE - HYST);
    localparam int                c_CW      = $clog2(COIN_STRETCH + 1);

    logic [2*NPLAYERS-1:0] w_pos;
    logic [2*NPLAYERS-1:0] w_neg;
    logic [NPLAYERS*4-1:0] w_dir_nx;
    logic [NPLAYERS-1:0]   w_act;
    logic [NPLAYERS-1:0]   w_coin_bits;
    logic [PW-1:0]         w_lowest;
    logic                  w_any;
    logic                  w_coin_any;
    logic                  w_coin_rise;
    logic [c_CW-1:0]       w_cnt_nx;

    logic                  r_coin_prev;
    logic [c_CW-1:0]       r_cnt;

    // Axis i belongs to player i/2; even i is X, odd i is Y.
    for (genvar i = 0; i < 2 * NPLAYERS; i++) begin : g_axis
        logic signed [8:0] w_v;
        logic [1:0]        r_st;
        logic [1:0]        w_nx;

        assign w_v = {joy_ana[8*i+7], joy_ana[8*i +: 8]};

        always_comb begin
            w_nx = r_st;
            case (r_st)
                c_POS: begin
                    if (w_v <= -c_ENGAGE)     w_nx = c_NEG;
                    else if (w_v < c_RELEASE) w_nx = c_CENTER;
                end
                c_NEG: begin
                    if (w_v >= c_ENGAGE)       w_nx = c_POS;
                    else if (w_v > -c_RELEASE) w_nx = c_CENTER;
                end
                default: begin
                    if (w_v >= c_ENGAGE)       w_nx = c_POS;
                    else if (w_v <= -c_ENGAGE) w_nx = c_NEG;
                    else                       w_nx = c_CENTER;
                end
            endcase
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) r_st <= c_CENTER;
            else          r_st <= w_nx;
        end

        assign w_pos[i] = (w_nx == c_POS);
        assign w_neg[i] = (w_nx == c_NEG);
    end

    for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
        assign w_dir_nx[4*p +: 4] = {w_neg[2*p+1], w_pos[2*p+1], w_neg[2*p], w_pos[2*p]}
                                  | joy_dig[32*p +: 4];
        assign w_act[p]       = (|joy_dig[32*p +: 32]) | w_pos[2*p] | w_neg[2*p]
                              | w_pos[2*p+1] | w_neg[2*p+1];
        assign w_coin_bits[p] = joy_dig[32*p+7];
    end

    // Descending scan so the lowest active index is the last one written.
    always_comb begin
        w_lowest = '0;
        for (int p = NPLAYERS - 1; p >= 0; p--) begin
            if (w_act[p]) w_lowest = PW'(p);
        end
    end

    assign w_any       = |w_act;
    assign w_coin_any  = |w_coin_bits;
    assign w_coin_rise = w_coin_any & ~r_coin_prev;
    assign w_cnt_nx    = w_coin_rise     ? c_CW'(COIN_STRETCH) :
                         (r_cnt != '0)   ? r_cnt - 1'b1        : '0;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dir_out       <= '0;
            coin_out      <= 1'b0;
            active_player <= '0;
            any_active    <= 1'b0;
            r_coin_prev   <= 1'b0;
            r_cnt         <= '0;
        end else begin
            dir_out     <= w_dir_nx;
            any_active  <= w_any;
            r_coin_prev <= w_coin_any;
            r_cnt       <= w_cnt_nx;
            coin_out    <= (w_cnt_nx != '0);
            if (w_any) active_player <= w_lowest;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_joy_analog_cond.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_joy_analog_cond                                            |
// | Desc     : Self-checking bench: directed scenarios plus randomized run   |
// |            against a behavioural model.                                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_joy_analog_cond;

    localparam int NP   = 2;
    localparam int DZ   = 32;
    localparam int HY   = 8;
    localparam int CS   = 16;
    localparam int PW   = 1;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b1;
    logic [NP*32-1:0]  joy_dig = '0;
    logic [NP*16-1:0]  joy_ana = '0;
    logic [NP*4-1:0]   dir_out;
    logic              coin_out;
    logic [PW-1:0]     active_player;
    logic              any_active;

    int n_checks = 0;
    int n_err    = 0;
    logic chk_en = 1'b0;

    joy_analog_cond #(
        .NPLAYERS(NP), .DEADZONE(DZ), .HYST(HY), .COIN_STRETCH(CS), .PW(PW)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .joy_dig(joy_dig), .joy_ana(joy_ana),
        .dir_out(dir_out), .coin_out(coin_out), .active_player(active_player),
        .any_active(any_active)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Axis direction as -1/0/+1: full deflection engages, partial deflection
    // only keeps an already-engaged direction alive.
    function automatic int ax_next(input int cur, input int v);
        if (v >= DZ)                      return 1;
        if (v <= -DZ)                     return -1;
        if (cur == 1  && v >= DZ - HY)    return 1;
        if (cur == -1 && v <= -(DZ - HY)) return -1;
        return 0;
    endfunction

    int              m_ax [2*NP];
    int              nx   [2*NP];
    logic [NP*4-1:0] m_dir = '0;
    logic [NP*4-1:0] nx_dir;
    logic [NP-1:0]   nx_act;
    int              nx_low;
    logic            nx_any;
    logic [PW-1:0]   m_ap = '0;
    logic            m_any = 1'b0;
    logic            coin_any;
    logic            m_coin_prev = 1'b0;
    logic            m_has_edge = 1'b0;
    int              m_cyc = 0;
    int              m_last = 0;
    logic            m_coin_exp;

    initial for (int i = 0; i < 2*NP; i++) m_ax[i] = 0;

    always_comb begin
        nx_dir   = '0;
        nx_act   = '0;
        nx_low   = 0;
        coin_any = 1'b0;
        for (int i = 0; i < 2*NP; i++) nx[i] = ax_next(m_ax[i], int'($signed(joy_ana[8*i +: 8])));
        for (int p = 0; p < NP; p++) begin
            nx_dir[4*p+0] = (nx[2*p]   ==  1) | joy_dig[32*p+0];
            nx_dir[4*p+1] = (nx[2*p]   == -1) | joy_dig[32*p+1];
            nx_dir[4*p+2] = (nx[2*p+1] ==  1) | joy_dig[32*p+2];
            nx_dir[4*p+3] = (nx[2*p+1] == -1) | joy_dig[32*p+3];
            nx_act[p] = (joy_dig[32*p +: 32] != 0) || nx[2*p] != 0 || nx[2*p+1] != 0;
            coin_any  = coin_any | joy_dig[32*p+7];
        end
        for (int p = NP - 1; p >= 0; p--) if (nx_act[p]) nx_low = p;
        nx_any = |nx_act;
        m_coin_exp = m_has_edge && ((m_cyc - m_last) < CS);
    end

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2*NP; i++) m_ax[i] <= 0;
            m_dir       <= '0;
            m_ap        <= '0;
            m_any       <= 1'b0;
            m_coin_prev <= 1'b0;
            m_has_edge  <= 1'b0;
        end else begin
            for (int i = 0; i < 2*NP; i++) m_ax[i] <= nx[i];
            m_dir       <= nx_dir;
            m_any       <= nx_any;
            if (nx_any) m_ap <= PW'(nx_low);
            m_coin_prev <= coin_any;
            m_cyc       <= m_cyc + 1;
            if (coin_any && !m_coin_prev) begin
                m_has_edge <= 1'b1;
                m_last     <= m_cyc + 1;
            end
        end
    end

    always @(negedge clk_sys) begin
        if (chk_en) begin
            chk("model_dir_out", 64'(dir_out), 64'(m_dir));
            chk("model_coin_out", 64'(coin_out), 64'(m_coin_exp));
            chk("model_active_player", 64'(active_player), 64'(m_ap));
            chk("model_any_active", 64'(any_active), 64'(m_any));
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    function automatic logic [7:0] rand_axis();
        int sel;
        int pick [15];
        pick = '{0, 23, 24, 25, 31, 32, 33, -23, -24, -25, -31, -32, -33, -128, 127};
        sel = $urandom_range(0, 9);
        if (sel < 4) return 8'($urandom_range(0, 255));
        return 8'(pick[$urandom_range(0, 14)]);
    endfunction

    initial begin
        int n;
        #1 reset_n = 1'b0;
        #1 chk_en = 1'b1;

        // Reset with P0 stick deflected right
        joy_ana[7:0] = 8'd100;
        repeat (3) tick();
        chk("reset_dir", 64'(dir_out), 64'h0);
        chk("reset_coin", 64'(coin_out), 64'h0);
        reset_n = 1'b1;
        #1 chk("release_before_edge", 64'(dir_out[3:0]), 64'h0);
        tick();
        chk("release_right", 64'(dir_out[0]), 64'h1);
        chk("release_ap", 64'(active_player), 64'h0);
        chk("release_any", 64'(any_active), 64'h1);

        // Hysteresis on P0 X
        begin
            int xs [5];
            int ex [5];
            xs = '{0, 32, 25, 23, 0};
            ex = '{0, 1, 1, 0, 0};
            for (int k = 0; k < 5; k++) begin
                joy_ana[7:0] = 8'(xs[k]);
                tick();
                chk("hyst_right", 64'(dir_out[0]), 64'(ex[k]));
            end
        end

        // Direct reversal on P1 Y, then X = -128
        joy_ana[31:24] = 8'd60;
        tick();
        chk("rev_down", 64'(dir_out[7:6]), 64'h1);
        joy_ana[31:24] = 8'(-60);
        tick();
        chk("rev_up", 64'(dir_out[7:6]), 64'h2);
        joy_ana[31:24] = 8'd0;
        joy_ana[7:0]   = 8'h80;
        tick();
        chk("x_min_left", 64'(dir_out[1:0]), 64'h2);
        chk("p1_centered", 64'(dir_out[7:4]), 64'h0);
        joy_ana[7:0] = 8'd0;
        repeat (2) tick();

        // Activity tracking
        joy_dig[35] = 1'b1;
        tick();
        chk("act_p1", 64'(active_player), 64'h1);
        chk("act_p1_any", 64'(any_active), 64'h1);
        joy_dig[35] = 1'b0;
        tick();
        chk("act_hold", 64'(active_player), 64'h1);
        chk("act_idle_any", 64'(any_active), 64'h0);
        joy_dig[0]  = 1'b1;
        joy_dig[35] = 1'b1;
        tick();
        chk("act_lowest", 64'(active_player), 64'h0);
        joy_dig = '0;
        repeat (2) tick();

        // Single-cycle coin
        chk("coin_idle", 64'(coin_out), 64'h0);
        joy_dig[39] = 1'b1;
        tick();
        chk("coin_start", 64'(coin_out), 64'h1);
        joy_dig[39] = 1'b0;
        n = 1;
        repeat (24) begin tick(); n += int'(coin_out); end
        chk("coin_width", 64'(n), 64'd16);

        // Retrigger at cycle 10
        joy_dig[39] = 1'b1;
        tick();
        joy_dig[39] = 1'b0;
        n = 1;
        repeat (9) begin tick(); n += int'(coin_out); end
        chk("retrig_first_part", 64'(n), 64'd10);
        joy_dig[39] = 1'b1;
        tick();
        joy_dig[39] = 1'b0;
        n = int'(coin_out);
        repeat (24) begin tick(); n += int'(coin_out); end
        chk("retrig_width", 64'(n), 64'd16);

        // Held coin
        joy_dig[7] = 1'b1;
        n = 0;
        repeat (100) begin tick(); n += int'(coin_out); end
        joy_dig[7] = 1'b0;
        repeat (20) begin tick(); n += int'(coin_out); end
        chk("held_width", 64'(n), 64'd16);

        // Async reset mid-stretch
        joy_dig[39] = 1'b1;
        tick();
        joy_dig[39] = 1'b0;
        repeat (4) tick();
        chk("mid_pulse_high", 64'(coin_out), 64'h1);
        reset_n = 1'b0;
        #1 chk("async_coin_clear", 64'(coin_out), 64'h0);
        chk("async_any_clear", 64'(any_active), 64'h0);
        tick();
        reset_n = 1'b1;
        n = 0;
        repeat (20) begin tick(); n += int'(coin_out); end
        chk("no_pulse_after_reset", 64'(n), 64'd0);

        // Randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2*NP; i++)
                if ($urandom_range(0, 1) == 0) joy_ana[8*i +: 8] = rand_axis();
            for (int p = 0; p < NP; p++) begin
                joy_dig[32*p +: 4] = '0;
                if ($urandom_range(0, 5) == 0) joy_dig[32*p + $urandom_range(0, 3)] = 1'b1;
                if ($urandom_range(0, 11) == 0) joy_dig[32*p+7] = ~joy_dig[32*p+7];
                joy_dig[32*p+12] = ($urandom_range(0, 29) == 0);
            end
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
            tick();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/joy_analog_cond.md
Name: joy_analog_cond

Overview:
- Input conditioner between hps_io and the Williams2 game core.
- Converts per-player left-stick analog data into debounced 4-way direction bits using a deadzone with hysteresis, and ORs them with the digital d-pad.
- Tracks the most recently active player, replacing the ad-hoc two-player latch, for any player count.
- Stretches coin inputs to a guaranteed minimum pulse width.

Parameters:
- NPLAYERS, 2, number of player channels (1..4).
- DEADZONE, 32, analog magnitude at which an axis engages (1..127).
- HYST, 8, release threshold is DEADZONE-HYST; must be < DEADZONE.
- COIN_STRETCH, 16, coin_out high time in clk_sys cycles (>=2).
- PW, $clog2(NPLAYERS) (min 1), width of active_player.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- joy_dig  in  NPLAYERS*32  hps_io joystick words; player p at [32p+31:32p].
  - bit0 right, 1 left, 2 down, 3 up, 7 coin.
- joy_ana  in  NPLAYERS*16  analog words; player p at [16p+15:16p].
  - [7:0] X, two's complement, +right.
  - [15:8] Y, two's complement, +down.
- dir_out  out  NPLAYERS*4  per player {up,down,left,right}, registered.
- coin_out  out  1  stretched coin pulse, registered.
- active_player  out  PW  index of the last player showing activity.
- any_active  out  1  high in a cycle where any player shows activity (registered).

Behaviour:
- Reset (reset_n low, asynchronous):
  - dir_out=0, coin_out=0, active_player=0, any_active=0.
  - All axis states CENTER; coin counter 0; coin edge registers 0.
- Axis FSM (one per player per axis, 2*NPLAYERS instances):
  - Input v is the signed 8-bit axis value. States are CENTER, POS, NEG.
  - CENTER -> POS if v >= DEADZONE; CENTER -> NEG if v <= -DEADZONE; otherwise stay.
  - POS -> CENTER if v < DEADZONE-HYST; POS -> NEG directly if v <= -DEADZONE.
  - NEG -> CENTER if v > -(DEADZONE-HYST); NEG -> POS directly if v >= DEADZONE.
  - Comparisons are signed on 9 bits so that v=-128 compares correctly.
  - X POS = right, X NEG = left; Y POS = down, Y NEG = up.
- dir_out:
  - Per player, dir_out = {up,down,left,right} from the FSM next-state, ORed with joy_dig bits {3,2,1,0}.
  - Latency is exactly 1 clk_sys from input change to dir_out, for both the analog and digital paths.
  - Opposite directions may both be asserted only when the digital and analog sources disagree; the block does not arbitrate them.
- Activity and active player:
  - Player p is active in a cycle if joy_dig[p] != 0 or either axis next-state != CENTER.
  - If any player is active: active_player <= lowest active index, any_active <= 1.
  - Otherwise active_player holds and any_active <= 0.
  - With simultaneous activity the lowest index wins.
- Coin:
  - Synchronous edge detect on the OR of bit7 across all players (previous-cycle register).
  - A rising edge loads the counter with COIN_STRETCH; coin_out is high while counter != 0; the counter decrements each cycle.
  - A new rising edge while the counter is nonzero reloads it to COIN_STRETCH (retrigger).
  - A held coin does not retrigger; a new edge requires release first.
  - coin_out rises 1 cycle after the edge and stays high exactly COIN_STRETCH cycles absent retrigger.
- Reset asserted mid-stretch or mid-deflection: outputs clear immediately.
  - After release, with a stick still deflected past DEADZONE, the direction asserts 1 cycle after the first clock edge.
- No combinational input-to-output paths.

Test Plan:
- Reset with joy_ana X=+100 for player 0, then release reset_n -> dir_out[0]=0 before the first edge; right=1 one cycle after the first edge; active_player=0.
- Hysteresis, P0 X sequence 0,32,25,23,0 (DEADZONE=32, HYST=8) -> right = 0,1,1,0,0, each one cycle delayed.
- Direct reversal, P1 Y from +60 to -60 in one step -> down drops and up rises in the same cycle; X=-128 -> left=1, no wraparound.
- Activity, NPLAYERS=2:
  - P1 d-pad up -> active_player=1.
  - P1 released -> active_player holds at 1, any_active=0.
  - P0 and P1 active together -> active_player=0.
- Coin, COIN_STRETCH=16:
  - 1-cycle coin on P1 -> coin_out high exactly 16 cycles, starting 1 cycle after the edge.
  - Second edge at cycle 10 -> coin_out stays high until 16 cycles after the second edge.
  - Coin held for 100 cycles -> single 16-cycle pulse.
- Async reset mid-pulse, reset_n low between clock edges at cycle 5 of the stretch -> coin_out=0 immediately; after release, no pulse without a new edge.
